// File: rtl/aurora_rx_seq_checker.sv
// Aurora 64B/66B RX incrementing-counter checker: acquires lock, counts good/bad words.
// Optional last-error capture enabled by defining AURORA_RX_CHK_LAST_ERR_EN.
module aurora_rx_seq_checker #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  user_clk,
  input  logic                  reset_n,
  input  logic                  channel_up,
  input  logic [DATA_WIDTH-1:0] rx_tdata,
  input  logic                  rx_tvalid,
  input  logic                  clear,
  output logic                  locked,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic                  err_pulse,
  output logic                  err_flag,
  output logic [DATA_WIDTH-1:0] last_err_expected,
  output logic [DATA_WIDTH-1:0] last_err_received
);

  localparam int unsigned RUN_W = $clog2(LOCK_COUNT + 1);
  localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] expected;
  logic [RUN_W-1:0]      run;
  logic                  match_c;
  logic                  run_done_c;

  // rx_tdata already carries the numeric counter value (lane bit order reversed upstream)
  assign match_c    = (rx_tdata == expected);
  assign run_done_c = ((run + RUN_W'(1)) == LOCK_RUN);

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_UNLOCKED;
      expected  <= '0;
      run       <= '0;
      locked    <= 1'b0;
      word_cnt  <= '0;
      err_cnt   <= '0;
      err_pulse <= 1'b0;
      err_flag  <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (!channel_up) begin
        state    <= ST_UNLOCKED;
        locked   <= 1'b0;
        run      <= '0;
        expected <= '0;
      end else if (rx_tvalid) begin
        // Resync on every beat so a single dropped/duplicated word costs one error
        expected <= rx_tdata + DATA_WIDTH'(1);
        case (state)
          ST_UNLOCKED: begin
            state <= ST_ACQUIRE;
            run   <= RUN_W'(1);
          end
          ST_ACQUIRE: begin
            if (!match_c) begin
              run <= RUN_W'(1);
            end else if (run_done_c) begin
              state  <= ST_LOCKED;
              locked <= 1'b1;
              run    <= '0;
            end else begin
              run <= run + RUN_W'(1);
            end
          end
          ST_LOCKED: begin
            if (match_c) begin
              run <= '0;
              if (word_cnt != '1) word_cnt <= word_cnt + CNT_WIDTH'(1);
            end else begin
              err_pulse <= 1'b1;
              err_flag  <= 1'b1;
              if (err_cnt != '1) err_cnt <= err_cnt + CNT_WIDTH'(1);
              if (run_done_c) begin
                state  <= ST_ACQUIRE;
                locked <= 1'b0;
                run    <= RUN_W'(1);
              end else begin
                run <= run + RUN_W'(1);
              end
            end
          end
          default: begin
            state  <= ST_UNLOCKED;
            locked <= 1'b0;
            run    <= '0;
          end
        endcase
      end
      // clear wins over same-cycle increments; err_pulse is left alone
      if (clear) begin
        word_cnt <= '0;
        err_cnt  <= '0;
        err_flag <= 1'b0;
      end
    end
  end

`ifdef AURORA_RX_CHK_LAST_ERR_EN
  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      last_err_expected <= '0;
      last_err_received <= '0;
    end else if (clear) begin
      last_err_expected <= '0;
      last_err_received <= '0;
    end else if (channel_up && rx_tvalid && (state == ST_LOCKED) && !match_c) begin
      last_err_expected <= expected;
      last_err_received <= rx_tdata;
    end
  end
`else
  assign last_err_expected = '0;
  assign last_err_received = '0;
`endif

endmodule
